// File: rtl/rr_arb16_ctrl_pkg.sv
// Shared constants, FSM state type and index helper for the 16-way round-robin arbiter.
package arb16_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = idx | SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb16_ctrl_if.sv
// Request/grant bundle between the requesting channels (master) and the arbiter (slave).
interface rr_arb16_ctrl_if;
   import arb16_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             gnt_valid;
   logic             timeout;

   modport master (output req, done, input gnt, sel, gnt_valid, timeout);
   modport slave  (input req, done, output gnt, sel, gnt_valid, timeout);

endinterface

// File: rtl/rr_arb16_ctrl_pick16.sv
// Combinational round-robin picker: first set bit of (req & ~excl) at or above ptr, wrapping.
module rr_pick16
   import arb16_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   input  logic [N_REQ-1:0] excl,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   always_comb begin
      masked = req & ~excl;
      // rot[0] is the candidate at ptr, so a plain lowest-bit search gives rotating priority
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = masked[SEL_W'(i) + ptr];
      end
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
      any = |rot;
      idx = off + ptr;
   end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter for a shared 16:1 mux with bounded grant tenure (HOLD_MAX).
// Define ARB_DEADCYCLE_EN to insert a one-cycle all-zero GAP after every release.
module rr_arb16_ctrl
   import arb16_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arb16_ctrl_if.slave bus
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t           state, state_d;
   logic [SEL_W-1:0] ptr, ptr_d;
   logic [7:0]       hold_cnt, hold_d;
   logic [N_REQ-1:0] gnt, gnt_d;
   logic [SEL_W-1:0] sel, sel_d;
   logic             gnt_valid, timeout, timeout_d;

   logic             pick_any;
   logic [SEL_W-1:0] pick_idx, pick_ptr;
   logic [N_REQ-1:0] pick_excl;
   logic             owner_req, expire, rel;

   // While owning, re-arbitration starts past the owner and skips it
   assign pick_ptr  = (state == OWN) ? sel + 4'd1 : ptr;
   assign pick_excl = (state == OWN) ? (N_REQ'(1) << sel) : '0;

   rr_pick16 u_pick (
      .req  (bus.req),
      .ptr  (pick_ptr),
      .excl (pick_excl),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign owner_req = bus.req[sel];
   assign expire    = (hold_cnt == HOLD_LAST);
   assign rel       = bus.done | ~owner_req | expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         sel       <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         hold_cnt  <= hold_d;
         gnt       <= gnt_d;
         sel       <= sel_d;
         gnt_valid <= |gnt_d;
         timeout   <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      hold_d    = hold_cnt;
      gnt_d     = gnt;
      sel_d     = sel;
      timeout_d = 1'b0;
      case (state)
         IDLE, GAP: begin
            if (pick_any) begin
               state_d = OWN;
               gnt_d   = N_REQ'(1) << pick_idx;
               sel_d   = onehot_to_idx(gnt_d);
               hold_d  = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         OWN: begin
            if (!rel) begin
               hold_d = hold_cnt + 8'd1;
            end else begin
               ptr_d     = sel + 4'd1;
               timeout_d = expire & ~bus.done & owner_req;
`ifdef ARB_DEADCYCLE_EN
               state_d = GAP;
               gnt_d   = '0;
`else
               if (pick_any) begin
                  gnt_d  = N_REQ'(1) << pick_idx;
                  sel_d  = onehot_to_idx(gnt_d);
                  hold_d = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   assign bus.gnt       = gnt;
   assign bus.sel       = sel;
   assign bus.gnt_valid = gnt_valid;
   assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Bench for rr_arb16_ctrl: vector table, directed corner sequences and randomized traffic vs a queue-free model.
module tb_rr_arb16_ctrl;

   localparam int HOLD_MAX = 8;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   rr_arb16_ctrl_if bus ();

   rr_arb16_ctrl #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the resource, for how many cycles, and where priority starts
   int         m_owner;
   int         m_cycles;
   int         m_ptr;
   logic [3:0] m_sel;
   logic       m_to;

   function automatic int rr_find(input logic [15:0] r, input int p, input int excl);
      for (int k = 0; k < 16; k++) begin
         int i;
         i = (p + k) % 16;
         if (i != excl && r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_cycles = 0;
      m_ptr    = 0;
      m_sel    = 4'd0;
      m_to     = 1'b0;
   endtask

   task automatic model_step(input logic [15:0] r, input logic d);
      int w;
      int old;
      bit exp_hit;
      w    = -1;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         exp_hit = (m_cycles == HOLD_MAX);
         if (!d && r[m_owner] && !exp_hit) begin
            m_cycles++;
            return;
         end
         m_to    = exp_hit && !d && r[m_owner];
         old     = m_owner;
         m_ptr   = (old + 1) % 16;
         m_owner = -1;
`ifdef ARB_DEADCYCLE_EN
         return;
`else
         w = rr_find(r, m_ptr, old);
`endif
      end else begin
         w = rr_find(r, m_ptr, -1);
      end
      if (w >= 0) begin
         m_owner  = w;
         m_sel    = 4'(w);
         m_cycles = 1;
      end
   endtask

   function automatic logic [15:0] model_gnt();
      return (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
      end
   endtask

   task automatic step(input logic [15:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      chk("model_gnt", 32'(bus.gnt), 32'(model_gnt()));
      chk("model_sel", 32'(bus.sel), 32'(m_sel));
      chk("model_gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
      chk("model_timeout", 32'(bus.timeout), 32'(m_to));
      chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
   endtask

   task automatic do_reset();
      #2;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;
      #1;
      model_reset();
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_sel", 32'(bus.sel), 32'h0);
      chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
      chk("rst_timeout", 32'(bus.timeout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] req;
      logic        done;
      logic [15:0] gnt;
      logic [3:0]  sel;
      logic        to;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      logic        d;

      tbl[0]  = '{16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0};
      tbl[1]  = '{16'h0010, 1'b0, 16'h0010, 4'd4, 1'b0};
      tbl[2]  = '{16'h0010, 1'b1, 16'h0000, 4'd4, 1'b0};
      tbl[3]  = '{16'h0021, 1'b0, 16'h0020, 4'd5, 1'b0};
      tbl[4]  = '{16'h0021, 1'b0, 16'h0020, 4'd5, 1'b0};
      tbl[5]  = '{16'h0000, 1'b0, 16'h0000, 4'd5, 1'b0};
      tbl[6]  = '{16'h0041, 1'b0, 16'h0040, 4'd6, 1'b0};
      tbl[7]  = '{16'h0000, 1'b1, 16'h0000, 4'd6, 1'b0};
      tbl[8]  = '{16'h0081, 1'b0, 16'h0080, 4'd7, 1'b0};
      tbl[9]  = '{16'h0000, 1'b0, 16'h0000, 4'd7, 1'b0};
      tbl[10] = '{16'h0003, 1'b0, 16'h0001, 4'd0, 1'b0};

      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_gnt", 32'(bus.gnt), 32'h0);
      chk("init_gnt_valid", 32'(bus.gnt_valid), 32'h0);
      chk("init_timeout", 32'(bus.timeout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].req, tbl[i].done);
         chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_sel", i), 32'(bus.sel), 32'(tbl[i].sel));
         chk($sformatf("tbl%0d_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].gnt != 0));
         chk($sformatf("tbl%0d_to", i), 32'(bus.timeout), 32'(tbl[i].to));
      end

      // Asynchronous reset in the middle of a grant
      step(16'h0004, 1'b0);
      step(16'h0004, 1'b0);
      do_reset();

      // Sole requester: 8 cycles of grant, expiry pulse, regrant after the idle cycle
      for (int i = 0; i < HOLD_MAX; i++) begin
         step(16'h0004, 1'b0);
         chk("to_hold_gnt", 32'(bus.gnt), 32'h0004);
         chk("to_hold_pulse", 32'(bus.timeout), 32'h0);
      end
      step(16'h0004, 1'b0);
      chk("to_expire_gnt", 32'(bus.gnt), 32'h0);
      chk("to_expire_pulse", 32'(bus.timeout), 32'h1);
      step(16'h0004, 1'b0);
      chk("to_regrant_gnt", 32'(bus.gnt), 32'h0004);
      chk("to_regrant_pulse", 32'(bus.timeout), 32'h0);
      for (int i = 1; i < HOLD_MAX; i++) step(16'h0004, 1'b0);
      step(16'h0004, 1'b1);
      chk("to_coincide_gnt", 32'(bus.gnt), 32'h0);
      chk("to_coincide_pulse", 32'(bus.timeout), 32'h0);

      // Pointer now 3: all requesters active, grants must walk upward from 3
      step(16'hFFFF, 1'b0);
      chk("all_first_sel", 32'(bus.sel), 32'd3);
`ifndef ARB_DEADCYCLE_EN
      for (int k = 1; k < 16; k++) begin
         step(16'hFFFF, 1'b1);
         chk("all_order_sel", 32'(bus.sel), 32'((3 + k) % 16));
         chk("all_order_gnt", 32'(bus.gnt), 32'(16'(1) << ((3 + k) % 16)));
      end

      do_reset();
      step(16'h8001, 1'b0);
      chk("wrap_sel0", 32'(bus.sel), 32'd0);
      for (int k = 1; k < 4; k++) begin
         step(16'h8001, 1'b1);
         chk("wrap_sel", 32'(bus.sel), (k % 2 == 1) ? 32'd15 : 32'd0);
         chk("wrap_nogap", 32'(bus.gnt_valid), 32'h1);
      end
`else
      step(16'hFFFF, 1'b1);
      chk("all_gap_gnt", 32'(bus.gnt), 32'h0);
      step(16'hFFFF, 1'b0);
      chk("all_next_sel", 32'(bus.sel), 32'd4);

      do_reset();
      step(16'h0003, 1'b0);
      chk("dead_p0", 32'(bus.gnt), 32'h0001);
      step(16'h0003, 1'b1);
      chk("dead_p1", 32'(bus.gnt), 32'h0000);
      step(16'h0003, 1'b0);
      chk("dead_p2", 32'(bus.gnt), 32'h0002);
      step(16'h0003, 1'b1);
      chk("dead_p3", 32'(bus.gnt), 32'h0000);
      step(16'h0003, 1'b0);
      chk("dead_p4", 32'(bus.gnt), 32'h0001);
`endif

      // Randomized traffic; requests are held for stretches so expiry gets exercised
      r = 16'h0000;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0: r = 16'($urandom);
               1: r = 16'(1) << $urandom_range(0, 15);
               2: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
               default: r = 16'h0000;
            endcase
         end
         d = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 599) == 0) do_reset();
         step(r, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
